aes_uart_framer: RTL and testbench
==================================

# aes_uart_framer

Byte-level framing controller between the UART PHYs (`serial_rx`/`serial_tx`) and the AES-256 core inside `aes256_uart`. It assembles a 48-byte inbound frame into a 256-bit key and a 128-bit plaintext, pulses the core's start, and captures the 128-bit result. It then streams the result back as 16 bytes through `serial_tx`. A partial frame is discarded after an inter-byte timeout, so the host can resynchronise without a reset.

## Interface
- `KEY_BYTES`, 32: key bytes per frame; they arrive first.
- `TEXT_BYTES`, 16: plaintext bytes per frame and result bytes returned.
- `TIMEOUT_CYCLES`, 3480: maximum idle gap between bytes inside a frame (4 byte-times at 10 MHz / 115200 baud).

- `clk` in 1: single clock; one clock, all logic on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `rx_data` in 8: byte from `serial_rx`.
- `rx_new` in 1: one-cycle strobe; `rx_data` is valid this cycle.
- `tx_data` out 8: byte to `serial_tx`.
- `tx_new` out 1: one-cycle strobe to `serial_tx`.
- `tx_busy` in 1: `serial_tx` busy.
- `aes_key` out 256: assembled key.
- `aes_text` out 128: assembled plaintext.
- `aes_start` out 1: one-cycle start pulse to the core.
- `aes_done` in 1: one-cycle strobe from the core; `aes_result` is valid this cycle.
- `aes_result` in 128: ciphertext.
- `busy` out 1: high in every state except RECV.
- `frame_err` out 1: one-cycle pulse on a timeout discard or an overrun.

## Operation
- **Frame layout:** frame byte j (0..47) is bits `{text,key}[8j+:8]`.
  - Bytes 0..31 fill `aes_key[8j+:8]`.
  - Bytes 32..47 fill `aes_text[8(j-32)+:8]`.
- **Result order:** result byte i (0..15) is `aes_result[8i+:8]`, LSB byte first.
- **States:**
  - RECV: accept bytes. When the byte with `byte_cnt==47` is accepted, go to START.
  - START: assert `aes_start` for one cycle, go to WAIT_AES.
  - WAIT_AES: on `aes_done`, latch `aes_result` into `res_q`, clear `tx_idx`, go to SEND.
  - SEND: when `!tx_busy`, drive `tx_data=res_q[8*tx_idx+:8]` and `tx_new=1` for one cycle, go to HOLD.
  - HOLD: one guard cycle with `tx_busy` ignored, go to DRAIN.
  - DRAIN: wait for `!tx_busy`.
    - If `tx_idx==15`, go to RECV with `byte_cnt=0`.
    - Otherwise increment `tx_idx` and go to SEND.
- **Byte counter:** `byte_cnt` is 6 bits. It increments only on an accepted `rx_new` in RECV and is never compared beyond 47.
- **Timeout:** a gap counter runs in RECV while `byte_cnt!=0`.
  - It clears on every `rx_new`.
  - When it reaches `TIMEOUT_CYCLES-1`: set `byte_cnt` to 0, pulse `frame_err`, clear the gap counter.
  - `aes_key`/`aes_text` are not cleared.
  - The counter is held at 0 while `byte_cnt==0`.
- **Overrun:** `rx_new` outside RECV drops the byte and pulses `frame_err`.
- **Simultaneous events:** `rx_new` in the same cycle as the timeout terminal count counts as a byte. It clears the counter; no error is raised.
- **Output stability:** `aes_key`/`aes_text` change only on accepted bytes, so they are stable from START until the next frame's bytes arrive.
- **Unexpected done:** `aes_done` outside WAIT_AES is ignored.
- **Reset:** `rst` at any time, including mid-receive or mid-send, returns to RECV.
  - `byte_cnt`, `tx_idx`, gap counter, `res_q`, `aes_key`, `aes_text` all go to 0.
  - All strobes, `tx_data`, `busy` and `frame_err` are 0 in the cycle after `rst`.
  - An interrupted `serial_tx` byte is the PHY's concern.

## Timing
- `aes_start` is high in cycle N+1, where the last byte's `rx_new` is in cycle N.
- `aes_done` in cycle M gives the first `tx_new` in cycle M+2 at the earliest (SEND in M+1, strobe registered).
- `tx_new` is high exactly one cycle per byte; `tx_data` is held from `tx_new` until the next `tx_new`.
- Back-to-back bytes are separated by at least 3 cycles (SEND, HOLD, DRAIN) plus the `serial_tx` busy time.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- **`aes_uart_pkg`:**
  - state encoding localparams (RECV, START, WAIT_AES, SEND, HOLD, DRAIN);
  - `FRAME_BYTES = KEY_BYTES + TEXT_BYTES`;
  - `BYTE_W = 8`;
  - the timeout counter width function (`$clog2(TIMEOUT_CYCLES)`).
- **`aes_uart_tx_seq`:** the SEND/HOLD/DRAIN byte streamer (`res_q`, `tx_idx`, handshake) as one sub-module. The top FSM hands it a `go` pulse and waits for its `done`.

## Test plan
- **Golden frame:** all-zero key, then text 0x014730f80ac625fe84f026c60bfd547d, with an AES stub that returns 0x5c9d844ed46f9885085e5d6a4f94c7d7 after 20 cycles.
  - `aes_key==0` and `aes_text` as sent at `aes_start`.
  - Exactly one `aes_start`.
  - 16 `tx_new` strobes carrying 0xd7, 0xc7, 0x94 … 0x5c.
- **Back-to-back frames:** two golden frames through real `serial_tx`/`serial_rx` at 87 clocks/bit.
  - 32 bytes received, both result blocks correct.
  - `frame_err` never asserted.
- **Timeout:** send 10 bytes, idle 3480 cycles, then a full frame of key=0xFF..FF.
  - One `frame_err` pulse at the idle cycle `TIMEOUT_CYCLES-1` after byte 10.
  - The following frame is assembled with `aes_key` all-ones.
- **Overrun:** `rx_new` during WAIT_AES and again during DRAIN.
  - Two `frame_err` pulses.
  - The result is transmitted intact.
  - The next frame starts at `byte_cnt` 0.
- **Reset mid-send:** assert `rst` for 1 cycle after the 5th `tx_new`.
  - All outputs are 0 the next cycle.
  - No further `tx_new`.
  - A new golden frame completes correctly.
- **Boundary:** `rx_new` on the exact timeout terminal cycle with `byte_cnt`=20.
  - The byte is counted and no `frame_err` is raised.
  - The frame completes after 27 more bytes.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared constants, state encodings and sizing helpers for the AES UART framer.
package aes_uart_pkg;

    localparam int KEY_BYTES      = 32;
    localparam int TEXT_BYTES     = 16;
    localparam int TIMEOUT_CYCLES = 3480;
    localparam int FRAME_BYTES    = KEY_BYTES + TEXT_BYTES;
    localparam int BYTE_W         = 8;

    localparam logic [2:0] S_RECV     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_WAIT_AES = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;
    localparam logic [2:0] S_DRAIN    = 3'd5;

    // Control FSM: CTL_XMIT covers the whole SEND/HOLD/DRAIN stream run by the streamer.
    typedef enum logic [2:0] {
        CTL_RECV     = S_RECV,
        CTL_START    = S_START,
        CTL_WAIT_AES = S_WAIT_AES,
        CTL_XMIT     = S_SEND
    } ctl_state_t;

    typedef enum logic [2:0] {
        TX_IDLE  = S_RECV,
        TX_SEND  = S_SEND,
        TX_HOLD  = S_HOLD,
        TX_DRAIN = S_DRAIN
    } tx_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GAP_W = cnt_width(TIMEOUT_CYCLES);

endpackage

// File: rtl/aes_uart_framer_tx_seq.sv
// Result streamer: latches the ciphertext on go and pushes it LSB byte first
// through the serial_tx handshake (SEND -> HOLD -> DRAIN per byte).
module aes_uart_framer_tx_seq
    import aes_uart_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    input  logic [TEXT_BYTES*BYTE_W-1:0] result,
    input  logic                         tx_busy,
    output logic [BYTE_W-1:0]            tx_data,
    output logic                         tx_new,
    output logic                         done
);

    localparam logic [3:0] LAST_IDX = 4'(TEXT_BYTES - 1);

    tx_state_t                     tx_state_r;
    tx_state_t                     tx_state_nx_s;
    logic [TEXT_BYTES*BYTE_W-1:0]  res_q_r;
    logic [3:0]                    tx_idx_r;
    logic [BYTE_W-1:0]             tx_data_r;
    logic                          tx_new_r;
    logic                          load_s;
    logic                          strobe_s;
    logic                          adv_s;
    logic                          done_s;

    // Next-state and handshake decode; HOLD ignores tx_busy so the PHY has a cycle to raise it.
    always_comb begin
        tx_state_nx_s = tx_state_r;
        load_s        = 1'b0;
        strobe_s      = 1'b0;
        adv_s         = 1'b0;
        done_s        = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (go) begin
                    load_s        = 1'b1;
                    tx_state_nx_s = TX_SEND;
                end else begin
                    tx_state_nx_s = TX_IDLE;
                end
            end
            TX_SEND: begin
                if (!tx_busy) begin
                    strobe_s      = 1'b1;
                    tx_state_nx_s = TX_HOLD;
                end else begin
                    tx_state_nx_s = TX_SEND;
                end
            end
            TX_HOLD: tx_state_nx_s = TX_DRAIN;
            TX_DRAIN: begin
                if (!tx_busy) begin
                    if (tx_idx_r == LAST_IDX) begin
                        done_s        = 1'b1;
                        tx_state_nx_s = TX_IDLE;
                    end else begin
                        adv_s         = 1'b1;
                        tx_state_nx_s = TX_SEND;
                    end
                end else begin
                    tx_state_nx_s = TX_DRAIN;
                end
            end
            default: tx_state_nx_s = TX_IDLE;
        endcase
    end

    // State, result buffer, byte index and registered strobe/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            res_q_r    <= {(TEXT_BYTES*BYTE_W){1'b0}};
            tx_idx_r   <= 4'd0;
            tx_data_r  <= {BYTE_W{1'b0}};
            tx_new_r   <= 1'b0;
        end else begin
            tx_state_r <= tx_state_nx_s;
            tx_new_r   <= strobe_s;
            if (load_s) begin
                res_q_r  <= result;
                tx_idx_r <= 4'd0;
            end else if (adv_s) begin
                tx_idx_r <= tx_idx_r + 4'd1;
            end
            if (strobe_s) begin
                tx_data_r <= res_q_r[{tx_idx_r, 3'b000} +: BYTE_W];
            end
        end
    end

    assign tx_data = tx_data_r;
    assign tx_new  = tx_new_r;
    assign done    = done_s;

endmodule

// File: rtl/aes_uart_framer.sv
// Framing controller: collects a 48-byte key+text frame from serial_rx, starts
// the AES core, and hands the result to the byte streamer for serial_tx.
module aes_uart_framer
    import aes_uart_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BYTE_W-1:0]            rx_data,
    input  logic                         rx_new,
    output logic [BYTE_W-1:0]            tx_data,
    output logic                         tx_new,
    input  logic                         tx_busy,
    output logic [KEY_BYTES*BYTE_W-1:0]  aes_key,
    output logic [TEXT_BYTES*BYTE_W-1:0] aes_text,
    output logic                         aes_start,
    input  logic                         aes_done,
    input  logic [TEXT_BYTES*BYTE_W-1:0] aes_result,
    output logic                         busy,
    output logic                         frame_err
);

    localparam logic [5:0]       LAST_BYTE = 6'(FRAME_BYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);

    ctl_state_t                     ctl_r;
    ctl_state_t                     ctl_nx_s;
    logic [FRAME_BYTES*BYTE_W-1:0]  frame_r;
    logic [5:0]                     byte_cnt_r;
    logic [GAP_W-1:0]               gap_r;
    logic                           aes_start_r;
    logic                           busy_r;
    logic                           frame_err_r;
    logic                           accept_s;
    logic                           last_s;
    logic                           timeout_s;
    logic                           overrun_s;
    logic                           go_s;
    logic                           tx_done_s;

    // Control decode; a byte arriving on the timeout terminal cycle wins over the timeout.
    always_comb begin
        ctl_nx_s  = ctl_r;
        accept_s  = 1'b0;
        last_s    = 1'b0;
        timeout_s = 1'b0;
        go_s      = 1'b0;
        overrun_s = rx_new && (ctl_r != CTL_RECV);
        case (ctl_r)
            CTL_RECV: begin
                if (rx_new) begin
                    accept_s = 1'b1;
                    last_s   = (byte_cnt_r == LAST_BYTE);
                end else begin
                    timeout_s = (byte_cnt_r != 6'd0) && (gap_r == GAP_LAST);
                end
                if (last_s) begin
                    ctl_nx_s = CTL_START;
                end else begin
                    ctl_nx_s = CTL_RECV;
                end
            end
            CTL_START: ctl_nx_s = CTL_WAIT_AES;
            CTL_WAIT_AES: begin
                if (aes_done) begin
                    go_s     = 1'b1;
                    ctl_nx_s = CTL_XMIT;
                end else begin
                    ctl_nx_s = CTL_WAIT_AES;
                end
            end
            CTL_XMIT: begin
                if (tx_done_s) begin
                    ctl_nx_s = CTL_RECV;
                end else begin
                    ctl_nx_s = CTL_XMIT;
                end
            end
            default: ctl_nx_s = CTL_RECV;
        endcase
    end

    // Frame assembly, byte/gap counters and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_r       <= CTL_RECV;
            frame_r     <= {(FRAME_BYTES*BYTE_W){1'b0}};
            byte_cnt_r  <= 6'd0;
            gap_r       <= {GAP_W{1'b0}};
            aes_start_r <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            ctl_r       <= ctl_nx_s;
            aes_start_r <= (ctl_nx_s == CTL_START);
            busy_r      <= (ctl_nx_s != CTL_RECV);
            frame_err_r <= timeout_s | overrun_s;
            if (accept_s) begin
                frame_r[{byte_cnt_r, 3'b000} +: BYTE_W] <= rx_data;
                byte_cnt_r <= last_s ? 6'd0 : byte_cnt_r + 6'd1;
            end else if (timeout_s) begin
                byte_cnt_r <= 6'd0;
            end
            // Gap timer only runs while a partial frame is pending.
            if ((ctl_r == CTL_RECV) && (byte_cnt_r != 6'd0) && !rx_new && !timeout_s) begin
                gap_r <= gap_r + GAP_W'(1);
            end else begin
                gap_r <= {GAP_W{1'b0}};
            end
        end
    end

    aes_uart_framer_tx_seq u_tx_seq (
        .clk     (clk),
        .rst     (rst),
        .go      (go_s),
        .result  (aes_result),
        .tx_busy (tx_busy),
        .tx_data (tx_data),
        .tx_new  (tx_new),
        .done    (tx_done_s)
    );

    assign aes_key   = frame_r[KEY_BYTES*BYTE_W-1:0];
    assign aes_text  = frame_r[FRAME_BYTES*BYTE_W-1:KEY_BYTES*BYTE_W];
    assign aes_start = aes_start_r;
    assign busy      = busy_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_aes_uart_framer.sv
// Directed bench for aes_uart_framer: frame vectors, timeout, overrun, reset and boundary cases.
module tb_aes_uart_framer;

    localparam logic [127:0] GOLD_TEXT = 128'h014730f80ac625fe84f026c60bfd547d;
    localparam logic [127:0] GOLD_RES  = 128'h5c9d844ed46f9885085e5d6a4f94c7d7;
    localparam int STUB_DLY = 20;
    localparam int BUSY_CYC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_new;
    logic [7:0]   tx_data;
    logic         tx_new;
    logic         tx_busy = 1'b0;
    logic [255:0] aes_key;
    logic [127:0] aes_text;
    logic         aes_start;
    logic         aes_done = 1'b0;
    logic [127:0] aes_result = 128'h0;
    logic         busy;
    logic         frame_err;

    int total = 0;
    int bad = 0;

    aes_uart_framer dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_new(rx_new),
        .tx_data(tx_data), .tx_new(tx_new), .tx_busy(tx_busy),
        .aes_key(aes_key), .aes_text(aes_text), .aes_start(aes_start),
        .aes_done(aes_done), .aes_result(aes_result),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // AES stub, serial_tx busy model and output monitor, all on the falling edge.
    logic [127:0] stub_result = 128'h0;
    logic [255:0] start_key = 256'h0;
    logic [127:0] start_text = 128'h0;
    logic [7:0]   tx_q[$];
    logic [7:0]   last_data = 8'h0;
    logic         prev_tx_new = 1'b0;
    logic         hold_en = 1'b0;
    int stub_cnt = 0;
    int busy_cnt = 0;
    int n_start = 0;
    int n_ferr = 0;
    int hold_err = 0;
    int pulse_err = 0;

    always @(negedge clk) begin
        if (rst) begin
            stub_cnt = 0;
            busy_cnt = 0;
            aes_done = 1'b0;
            tx_busy  = 1'b0;
        end else begin
            aes_done = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    aes_done   = 1'b1;
                    aes_result = stub_result;
                end
            end
            if (aes_start) begin
                n_start++;
                start_key  = aes_key;
                start_text = aes_text;
                stub_cnt   = STUB_DLY;
            end
            if (tx_new) begin
                tx_q.push_back(tx_data);
                busy_cnt = BUSY_CYC;
            end
            tx_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            if (frame_err) n_ferr++;
        end
        if (tx_new && prev_tx_new) pulse_err++;
        if (hold_en && !tx_new && (tx_data !== last_data)) hold_err++;
        prev_tx_new = tx_new;
        last_data   = tx_data;
    end

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bytes(input logic [383:0] fr, input int lo, input int hi);
        for (int j = lo; j <= hi; j++) begin
            @(negedge clk);
            rx_data = fr[8*j +: 8];
            rx_new  = 1'b1;
            @(negedge clk);
            rx_new  = 1'b0;
        end
    endtask

    task automatic finish_frame(input string tag, input logic [255:0] key, input logic [127:0] text,
                                input logic [127:0] res, input logic [7:0] f, input logic [7:0] l,
                                input int b_start, input int b_tx, input int b_ferr, input int exp_ferr);
        int cyc;
        logic [127:0] got;
        cyc = 0;
        while (!((tx_q.size() >= b_tx + 16) && (busy == 1'b0)) && (cyc < 4000)) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_complete"}, 384'(cyc < 4000), 384'(1));
        check({tag, "_starts"}, 384'(n_start - b_start), 384'(1));
        check({tag, "_key"}, 384'(start_key), 384'(key));
        check({tag, "_text"}, 384'(start_text), 384'(text));
        got = 128'h0;
        for (int i = 0; i < 16; i++) begin
            if (b_tx + i < tx_q.size()) got[8*i +: 8] = tx_q[b_tx + i];
        end
        check({tag, "_result"}, 384'(got), 384'(res));
        check({tag, "_first"}, 384'(got[7:0]), 384'(f));
        check({tag, "_last"}, 384'(got[127:120]), 384'(l));
        check({tag, "_ntx"}, 384'(tx_q.size() - b_tx), 384'(16));
        check({tag, "_ferr"}, 384'(n_ferr - b_ferr), 384'(exp_ferr));
    endtask

    task automatic run_frame(input string tag, input logic [255:0] key, input logic [127:0] text,
                             input logic [127:0] res, input logic [7:0] f, input logic [7:0] l);
        int b_start, b_tx, b_ferr;
        stub_result = res;
        b_start = n_start;
        b_tx    = tx_q.size();
        b_ferr  = n_ferr;
        send_bytes({text, key}, 0, 47);
        finish_frame(tag, key, text, res, f, l, b_start, b_tx, b_ferr, 0);
    endtask

    typedef struct {
        logic [255:0] key;
        logic [127:0] text;
        logic [127:0] result;
        logic [7:0]   exp_first;
        logic [7:0]   exp_last;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int b_start, b_tx, b_ferr, first_k, n_pulse, seen, guard;

        vecs[0] = '{256'h0, GOLD_TEXT, GOLD_RES, 8'hd7, 8'h5c};
        vecs[1] = '{{32{8'hff}}, 128'h00112233445566778899aabbccddeeff,
                    128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 8'hf0, 8'h0f};
        vecs[2] = '{256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100,
                    128'hfedcba98765432100123456789abcdef,
                    128'hdeadbeef0123456789abcdefcafef00d, 8'h0d, 8'hde};

        rst = 1'b1;
        rx_new = 1'b0;
        rx_data = 8'h0;
        repeat (3) @(negedge clk);
        check("reset_ctl", 384'({tx_data, tx_new, aes_start, busy, frame_err}), 384'(0));
        check("reset_key", 384'(aes_key), 384'(0));
        check("reset_text", 384'(aes_text), 384'(0));
        rst = 1'b0;
        hold_en = 1'b1;

        // Back-to-back frames from the vector table.
        for (int v = 0; v < 3; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].key, vecs[v].text, vecs[v].result,
                      vecs[v].exp_first, vecs[v].exp_last);
        end

        // Timeout: 10 bytes, then idle past the limit.
        send_bytes({GOLD_TEXT, {32{8'haa}}}, 0, 9);
        first_k = 0;
        n_pulse = 0;
        for (int k = 2; k <= 3490; k++) begin
            @(negedge clk);
            if (frame_err) begin
                n_pulse++;
                if (first_k == 0) first_k = k;
            end
        end
        check("timeout_pulses", 384'(n_pulse), 384'(1));
        check("timeout_cycle", 384'(first_k), 384'(3481));
        check("timeout_key_kept", 384'(aes_key), 384'({vecs[2].key[255:80], {10{8'haa}}}));
        run_frame("after_timeout", {32{8'hff}}, GOLD_TEXT, GOLD_RES, 8'hd7, 8'h5c);

        // Overrun during WAIT_AES and during DRAIN.
        stub_result = GOLD_RES;
        b_start = n_start;
        b_tx    = tx_q.size();
        b_ferr  = n_ferr;
        send_bytes({GOLD_TEXT, 256'h0}, 0, 47);
        repeat (3) @(negedge clk);
        rx_data = 8'hee;
        rx_new  = 1'b1;
        @(negedge clk);
        rx_new  = 1'b0;
        seen = 0;
        guard = 0;
        while ((seen < 3) && (guard < 2000)) begin
            @(negedge clk);
            guard++;
            if (tx_new) seen++;
        end
        repeat (2) @(negedge clk);
        rx_data = 8'h33;
        rx_new  = 1'b1;
        @(negedge clk);
        rx_new  = 1'b0;
        finish_frame("overrun", 256'h0, GOLD_TEXT, GOLD_RES, 8'hd7, 8'h5c, b_start, b_tx, b_ferr, 2);
        check("overrun_key_kept", 384'(aes_key), 384'(0));
        run_frame("after_overrun", vecs[2].key, vecs[2].text, vecs[2].result, 8'h0d, 8'hde);

        // Byte landing on the timeout terminal cycle with 20 bytes pending.
        stub_result = GOLD_RES;
        b_start = n_start;
        b_tx    = tx_q.size();
        b_ferr  = n_ferr;
        send_bytes({GOLD_TEXT, {32{8'h5a}}}, 0, 19);
        repeat (3478) @(negedge clk);
        send_bytes({GOLD_TEXT, {32{8'h5a}}}, 20, 47);
        finish_frame("boundary", {32{8'h5a}}, GOLD_TEXT, GOLD_RES, 8'hd7, 8'h5c, b_start, b_tx, b_ferr, 0);

        // Reset one cycle after the 5th transmitted byte.
        stub_result = vecs[1].result;
        send_bytes({vecs[1].text, vecs[1].key}, 0, 47);
        seen = 0;
        guard = 0;
        while ((seen < 5) && (guard < 2000)) begin
            @(negedge clk);
            guard++;
            if (tx_new) seen++;
        end
        check("rst_mid_reached", 384'(seen), 384'(5));
        hold_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ctl", 384'({tx_data, tx_new, aes_start, busy, frame_err}), 384'(0));
        check("rst_mid_key", 384'(aes_key), 384'(0));
        check("rst_mid_text", 384'(aes_text), 384'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        b_tx = tx_q.size();
        repeat (200) @(negedge clk);
        check("rst_mid_no_tx", 384'(tx_q.size() - b_tx), 384'(0));
        hold_en = 1'b1;
        run_frame("after_reset", 256'h0, GOLD_TEXT, GOLD_RES, 8'hd7, 8'h5c);

        check("tx_data_hold", 384'(hold_err), 384'(0));
        check("tx_new_width", 384'(pulse_err), 384'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
